// File: rtl/store_pkg.sv
// Shared encodings for the S-type store sequencer: opcodes, funct3 values,
// fault cause codes and FSM state type.
package store_pkg;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExec,
    StMem,
    StResp
  } state_e;

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane steering for SB/SH/SW: positions store data on the
// addressed lanes, builds byte enables and flags misaligned accesses.
module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_misaligned
);

  always_comb begin
    o_wdata      = '0;
    o_be         = '0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {24'b0, i_rs2[7:0]} << {i_addr_lo, 3'b000};
      end
      F3_SH: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = i_addr_lo[1] ? {i_rs2[15:0], 16'b0} : {16'b0, i_rs2[15:0]};
        o_misaligned = i_addr_lo[0];
      end
      F3_SW: begin
        o_be         = 4'b1111;
        o_wdata      = i_rs2;
        o_misaligned = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_sequencer.sv
// Multi-cycle S-type store controller: accept, decode, read registers, form
// the effective address and lanes, then run a req/ack write with timeout.
module store_sequencer
  import store_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr_word,
  output logic            instr_ready,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT - 1);

  state_e          r_state;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_be;
  logic [1:0]      r_cause;
  logic [CntW-1:0] r_cnt;

  state_e          w_state_next;
  logic [1:0]      w_cause_next;
  logic [CntW-1:0] w_cnt_next;
  logic            w_latch_instr;
  logic            w_capture;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_eff_addr;
  logic [XLEN-1:0] w_lane_wdata;
  logic [3:0]      w_lane_be;
  logic            w_misaligned;
  logic            w_rf_active;

  assign w_opcode   = r_instr[6:0];
  assign w_funct3   = r_instr[14:12];
  assign w_imm      = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_eff_addr = rf_rs1_data + w_imm;

  store_lane_align u_lane_align (
    .i_funct3     (w_funct3),
    .i_addr_lo    (w_eff_addr[1:0]),
    .i_rs2        (rf_rs2_data),
    .o_wdata      (w_lane_wdata),
    .o_be         (w_lane_be),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_instr <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cause <= CAUSE_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
      r_cnt   <= w_cnt_next;
      if (w_latch_instr) r_instr <= instr_word;
      if (w_capture) begin
        r_addr  <= w_eff_addr;
        r_wdata <= w_lane_wdata;
        r_be    <= w_lane_be;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cause_next  = r_cause;
    w_cnt_next    = r_cnt;
    w_latch_instr = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      StIdle: begin
        if (instr_valid) begin
          w_latch_instr = 1'b1;
          w_cause_next  = CAUSE_NONE;
          w_state_next  = StDecode;
        end
      end
      StDecode: begin
        if (w_opcode == OP_STORE && is_store_f3(w_funct3)) begin
          w_state_next = StExec;
        end else begin
          w_cause_next = CAUSE_ILLEGAL;
          w_state_next = StResp;
        end
      end
      StExec: begin
        w_capture = 1'b1;
        if (w_misaligned) begin
          w_cause_next = CAUSE_MISALIGN;
          w_state_next = StResp;
        end else begin
          w_cnt_next   = '0;
          w_state_next = StMem;
        end
      end
      StMem: begin
        // An ack in the last permitted cycle still counts as success.
        if (mem_ack) begin
          w_cause_next = CAUSE_NONE;
          w_state_next = StResp;
        end else if (r_cnt == CntMax) begin
          w_cause_next = CAUSE_TIMEOUT;
          w_state_next = StResp;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_rf_active = (r_state == StDecode) || (r_state == StExec);

  assign instr_ready = (r_state == StIdle) && !rst;
  assign rf_rs1_addr = w_rf_active ? r_instr[19:15] : 5'd0;
  assign rf_rs2_addr = w_rf_active ? r_instr[24:20] : 5'd0;

  assign mem_req   = (r_state == StMem);
  assign mem_addr  = mem_req ? r_addr : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;
  assign mem_be    = mem_req ? r_be : 4'b0000;

  assign done        = (r_state == StResp) && (r_cause == CAUSE_NONE);
  assign fault       = (r_state == StResp) && (r_cause != CAUSE_NONE);
  assign fault_cause = fault ? r_cause : CAUSE_NONE;

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: one task per scenario with inline checks
// against hand-computed expectations and a small register-file model.
module tb_store_sequencer;

  localparam logic [6:0] OP = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_word;
  logic        instr_ready;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;

  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        hs_ok;

  always #5 clk = ~clk;

  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  store_sequencer #(
    .XLEN        (32),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_word  (instr_word),
    .instr_ready (instr_ready),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .done        (done),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] w);
    instr_valid = 1'b1;
    instr_word  = w;
    hs_ok       = instr_ready;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Walks through MEM until RESP, acking on the ack_at-th req cycle (0 = never).
  task automatic run_mem(input int ack_at, output int reqs, output logic got_done,
                         output logic got_fault, output logic [1:0] cause);
    reqs = 0; got_done = 1'b0; got_fault = 1'b0; cause = 2'b00;
    for (int k = 0; k < 60; k++) begin
      if (done || fault) begin
        got_done = done; got_fault = fault; cause = fault_cause;
        break;
      end
      if (mem_req) reqs++;
      mem_ack = mem_req && (reqs == ack_at);
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; instr_word = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", instr_ready); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_req); end
    n_checks++; if ({done, fault, fault_cause} !== 4'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 0000", {done, fault, fault_cause}); end
    n_checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0) begin n_fail++; $display("FAIL rst_mem: got %h/%b want 0/0", mem_addr, mem_be); end
    rst = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", instr_ready); end
    @(negedge clk);
  endtask

  task automatic test_sw;
    rf[13] = 32'h0000_1003;
    issue({7'b0000111, 5'd0, 5'd13, 3'b010, 5'b11101, OP});
    n_checks++; if (hs_ok !== 1'b1) begin n_fail++; $display("FAIL sw_accept: got %b want 1", hs_ok); end
    n_checks++; if (rf_rs1_addr !== 5'd13 || rf_rs2_addr !== 5'd0) begin n_fail++; $display("FAIL sw_rfaddr: got %0d/%0d want 13/0", rf_rs1_addr, rf_rs2_addr); end
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL sw_busy_ready: got %b want 0", instr_ready); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL sw_exec: got req %b fault %b want 0 0", mem_req, fault); end
    n_checks++; if (rf_rs1_addr !== 5'd13) begin n_fail++; $display("FAIL sw_rfhold: got %0d want 13", rf_rs1_addr); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sw_req: got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h0000_1100) begin n_fail++; $display("FAIL sw_addr: got %h want 00001100", mem_addr); end
    n_checks++; if (mem_be !== 4'b1111 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL sw_lanes: got %b/%h want 1111/00000000", mem_be, mem_wdata); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if (done !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL sw_done: got done %b fault %b want 1 0", done, fault); end
    n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL sw_req_drop: got %b/%h want 0/0", mem_req, mem_addr); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_idle: got done %b ready %b want 0 1", done, instr_ready); end
  endtask

  task automatic test_sb;
    int reqs; logic d, f; logic [1:0] c;
    rf[1] = 32'h0000_2002; rf[2] = 32'h0000_00A5;
    issue({7'b1111111, 5'd2, 5'd1, 3'b000, 5'b11111, OP});
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (mem_addr !== 32'h0000_2001) begin n_fail++; $display("FAIL sb_addr: got %h want 00002001", mem_addr); end
    n_checks++; if (mem_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", mem_be); end
    n_checks++; if (mem_wdata !== 32'h0000_A500) begin n_fail++; $display("FAIL sb_wdata: got %h want 0000a500", mem_wdata); end
    run_mem(3, reqs, d, f, c);
    n_checks++; if (reqs !== 3) begin n_fail++; $display("FAIL sb_req_cycles: got %0d want 3", reqs); end
    n_checks++; if (d !== 1'b1 || f !== 1'b0) begin n_fail++; $display("FAIL sb_done: got done %b fault %b want 1 0", d, f); end
    @(negedge clk);
  endtask

  task automatic test_sh_lanes;
    rf[1] = 32'h0000_2002; rf[3] = 32'hDEAD_BEEF;
    issue({7'b0, 5'd3, 5'd1, 3'b001, 5'd0, OP});
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_0000) begin n_fail++; $display("FAIL sh_lanes: got %b/%h want 1100/beef0000", mem_be, mem_wdata); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sh_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_misalign;
    rf[1] = 32'h0000_2000;
    issue({7'b0, 5'd2, 5'd1, 3'b001, 5'd1, OP});
    @(negedge clk);
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %b want 0", fault); end
    @(negedge clk);
    n_checks++; if (fault !== 1'b1 || fault_cause !== 2'b10) begin n_fail++; $display("FAIL mis_sh_fault: got %b/%b want 1/10", fault, fault_cause); end
    n_checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mis_sh_noreq: got req %b done %b want 0 0", mem_req, done); end
    @(negedge clk);
    n_checks++; if (fault !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL mis_idle: got fault %b ready %b want 0 1", fault, instr_ready); end
    issue({7'b0, 5'd2, 5'd1, 3'b010, 5'd2, OP});
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (fault !== 1'b1 || fault_cause !== 2'b10 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_sw_fault: got %b/%b req %b want 1/10 0", fault, fault_cause, mem_req); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue({7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011});
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL ill_early: got %b want 0", fault); end
    @(negedge clk);
    n_checks++; if (fault !== 1'b1 || fault_cause !== 2'b01 || mem_req !== 1'b0) begin n_fail++; $display("FAIL ill_op_fault: got %b/%b req %b want 1/01 0", fault, fault_cause, mem_req); end
    @(negedge clk);
    issue({7'b0, 5'd2, 5'd1, 3'b011, 5'd0, OP});
    n_checks++; if (hs_ok !== 1'b1) begin n_fail++; $display("FAIL ill_next_accept: got %b want 1", hs_ok); end
    @(negedge clk);
    n_checks++; if (fault !== 1'b1 || fault_cause !== 2'b01 || mem_req !== 1'b0) begin n_fail++; $display("FAIL ill_f3_fault: got %b/%b req %b want 1/01 0", fault, fault_cause, mem_req); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int reqs; logic d, f; logic [1:0] c;
    rf[1] = 32'h0000_2000;
    issue({7'b0, 5'd2, 5'd1, 3'b010, 5'd0, OP});
    run_mem(0, reqs, d, f, c);
    n_checks++; if (reqs !== 16) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 16", reqs); end
    n_checks++; if (f !== 1'b1 || c !== 2'b11 || d !== 1'b0) begin n_fail++; $display("FAIL to_fault: got fault %b cause %b done %b want 1 11 0", f, c, d); end
    @(negedge clk);
    issue({7'b0, 5'd2, 5'd1, 3'b010, 5'd0, OP});
    run_mem(16, reqs, d, f, c);
    n_checks++; if (reqs !== 16) begin n_fail++; $display("FAIL to_last_req_cycles: got %0d want 16", reqs); end
    n_checks++; if (d !== 1'b1 || f !== 1'b0) begin n_fail++; $display("FAIL to_last_ack: got done %b fault %b want 1 0", d, f); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    rf[1] = 32'h0000_2000;
    issue({7'b0, 5'd2, 5'd1, 3'b010, 5'd0, OP});
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", mem_req); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL rm_abort: got req %b done %b fault %b want 0 0 0", mem_req, done, fault); end
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_rst: got %b want 0", instr_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b want 1", instr_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || fault || mem_req) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rm_quiet: got %0d activity cycles want 0", pulses); end
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int dn = 0;
    rf[13] = 32'h0000_1003;
    instr_word  = {7'b0000111, 5'd0, 5'd13, 3'b010, 5'b11101, OP};
    instr_valid = 1'b1;
    mem_ack     = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (instr_valid && instr_ready) acc++;
      if (done) dn++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    n_checks++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    n_checks++; if (dn !== 3) begin n_fail++; $display("FAIL b2b_dones: got %0d want 3", dn); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    test_reset();
    test_sw();
    test_sb();
    test_sh_lanes();
    test_misalign();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
Multi-cycle controller that sequences one RISC-V S-type store (SB/SH/SW) from instruction word to data-memory write. Accepts an instruction by valid/ready handshake and decodes the S-type fields. Reads rs1/rs2 from the register file, forms the effective address and byte lanes, then drives a req/ack write to data memory. Sits between fetch/decode and the data-memory port. Reports completion or a fault cause.

Parameters:
XLEN, 32, data/address width (only 32 supported)
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before timeout fault (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
instr_valid  in  1  instr_word valid
instr_word  in  32  instruction to execute
instr_ready  out  1  sequencer can accept; transfer when instr_valid & instr_ready
rf_rs1_addr  out  5  register-file read address A (instr[19:15])
rf_rs2_addr  out  5  register-file read address B (instr[24:20])
rf_rs1_data  in  32  combinational read data A
rf_rs2_data  in  32  combinational read data B
mem_req  out  1  write request, held until ack/timeout
mem_addr  out  32  byte effective address
mem_wdata  out  32  lane-aligned write data
mem_be  out  4  byte enables
mem_ack  in  1  memory accepted write
done  out  1  one-cycle pulse, store completed
fault  out  1  one-cycle pulse, store aborted
fault_cause  out  2  valid with fault: 01 illegal, 10 misaligned, 11 timeout; 00 otherwise

Behaviour:
- Reset: state IDLE; all outputs 0 (instr_ready 0 while rst high, 1 in first cycle after). Reset mid-operation aborts at that edge: mem_req drops, no done/fault pulse.
- FSM: IDLE -> DECODE -> EXEC -> MEM -> RESP -> IDLE.
- IDLE: instr_ready=1. On handshake, latch instr_word; go DECODE. instr_ready=0 in all other states; instr_valid ignored while busy.
- DECODE: drive rf_rs1_addr/rf_rs2_addr from latched word (held through EXEC). Illegal if opcode != 7'b0100011 or funct3 not in {000,001,010}. Illegal -> RESP with cause 01; no mem_req.
- EXEC: imm = sign-extend({instr[31:25],instr[11:7]}). addr = rf_rs1_data + imm, modulo 2^32 (wraps, no fault).
  - Capture addr, wdata and be.
  - Misaligned if SH with addr[0]=1, or SW with addr[1:0]!=0 -> RESP with cause 10; no mem_req. Otherwise go MEM.
- Lane rules:
  - SB: be=4'b0001<<addr[1:0]; wdata=rs2[7:0]<<(8*addr[1:0]).
  - SH: be=4'b0011<<(2*addr[1]); wdata=rs2[15:0]<<(16*addr[1]).
  - SW: be=1111; wdata=rs2. Unused lanes 0.
- MEM: mem_req=1, with mem_addr/mem_wdata/mem_be stable.
  - Timeout counter starts at 0 on MEM entry and increments each MEM cycle without ack.
  - mem_ack -> RESP success, mem_req low next cycle.
  - Counter reaches MEM_TIMEOUT-1 without ack -> RESP with cause 11 (mem_req high exactly MEM_TIMEOUT cycles). Ack in that final cycle wins (success).
  - mem_ack outside MEM is ignored.
- RESP: exactly one cycle. Pulse done (cause 00) or fault with fault_cause; then IDLE. mem_* outputs return to 0 when leaving MEM.
- Latency: handshake cycle 0, DECODE 1, EXEC 2, MEM 3. Ack in cycle 3 gives done in cycle 4. Illegal fault in cycle 2; misaligned fault in cycle 3. Next accept is the cycle after RESP.

Decomposition:
- Package store_pkg:
  - OP_STORE=7'b0100011
  - F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010
  - FSM state encoding
  - fault cause codes CAUSE_NONE/ILLEGAL/MISALIGN/TIMEOUT
- Sub-module store_lane_align (combinational): inputs funct3, addr[1:0], rs2 data; outputs wdata, be, misaligned. Unit-testable in isolation.

Test Plan:
- SW: word 0000111_00000_01101_010_11101_0100011 (imm=253, rs1=x13, rs2=x0); rf x13=0x00001003, x0=0; ack on first req cycle -> mem_addr 0x00001100, be 1111, wdata 0; done pulse 4 cycles after accept; fault 0.
- SB, imm=-1: word 1111111_00010_00001_000_11111_0100011; x1=0x00002002, x2=0x000000A5; ack after 3 cycles -> mem_addr 0x00002001, be 0010, wdata 0x0000A500; req high 3 cycles; done pulse.
- SH misaligned: imm=1, x1=0x00002000 -> fault with cause 10 in cycle 3; mem_req never asserts.
- Illegal: opcode 0110011, or funct3=011 with store opcode -> fault with cause 01 in cycle 2; no mem_req. Next instr accepted the cycle after.
- Timeout: MEM_TIMEOUT=16, ack held 0 -> mem_req high exactly 16 cycles, then fault cause 11. Repeat with ack in 16th cycle -> done, no fault.
- Reset mid-MEM and back-pressure:
  - rst high during mem_req -> mem_req 0 after that edge; no done/fault; instr_ready 1 first cycle after rst low.
  - instr_valid held high while busy -> only one instruction accepted per store.
